hit_locator: RTL

Scans the 128-entry y-axis and x-axis sample arrays once the upstream serial data aggregator reports a complete frame. For each axis it finds the peak strip (value and index) and the sum of samples at or above a threshold. It then presents one event record per frame to the downstream readout logic over a valid/ready handshake. It is the first consumer of the aggregator's read ports and `finished` flag in the autoradiography acquisition chain.

---
 rtl/autorad_pkg.sv | 16 +
 rtl/hit_locator_if.sv | 34 +++
 rtl/hit_locator_axis_peak_accum.sv | 54 +++++
 rtl/hit_locator.sv | 108 ++++++++++
 4 files changed

// File: rtl/autorad_pkg.sv
// Shared constants and types for the autoradiography acquisition chain.
package autorad_pkg;

  localparam int N_CH   = 128;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 7;
  localparam int SUM_W  = 23;

  // Frame scanner FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/hit_locator_if.sv
// Event record channel from hit_locator to the downstream readout logic.
//
// Handshake: event_valid is raised by the master when a record is present and
// stays high, with every record field held stable, until the first clock edge
// where event_ready is also high; that edge is the transfer. The slave may
// raise event_ready before event_valid. event_valid drops the cycle after the
// transfer.
interface hit_locator_if;
  import autorad_pkg::*;

  logic              event_valid;
  logic              event_ready;
  logic [IDX_W-1:0]  peak_idx_y;
  logic [IDX_W-1:0]  peak_idx_x;
  logic [DATA_W-1:0] peak_val_y;
  logic [DATA_W-1:0] peak_val_x;
  logic [SUM_W-1:0]  sum_y;
  logic [SUM_W-1:0]  sum_x;
  logic              hit_y;
  logic              hit_x;

  modport master (
    output event_valid, peak_idx_y, peak_idx_x, peak_val_y, peak_val_x,
           sum_y, sum_x, hit_y, hit_x,
    input  event_ready
  );

  modport slave (
    input  event_valid, peak_idx_y, peak_idx_x, peak_val_y, peak_val_x,
           sum_y, sum_x, hit_y, hit_x,
    output event_ready
  );

endinterface

// File: rtl/hit_locator_axis_peak_accum.sv
// Per-axis peak finder and thresholded sum accumulator.
module axis_peak_accum
  import autorad_pkg::*;
#(
  parameter logic [DATA_W-1:0] THRESHOLD = 16'd256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] peak_val_o,
  output logic [IDX_W-1:0]  peak_idx_o,
  output logic [SUM_W-1:0]  sum_o,
  output logic              hit_o
);

  logic [DATA_W-1:0] peak_val_q;
  logic [IDX_W-1:0]  peak_idx_q;
  logic [SUM_W-1:0]  sum_q;
  logic              hit_q;

  // Clear at frame start, then fold in one sample per enabled cycle.
  // Strict > keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_val_q <= '0;
      peak_idx_q <= '0;
      sum_q      <= '0;
      hit_q      <= 1'b0;
    end else if (clear_i) begin
      peak_val_q <= '0;
      peak_idx_q <= '0;
      sum_q      <= '0;
      hit_q      <= 1'b0;
    end else if (enable_i) begin
      if (data_i > peak_val_q) begin
        peak_val_q <= data_i;
        peak_idx_q <= idx_i;
      end
      if (data_i >= THRESHOLD) begin
        sum_q <= sum_q + SUM_W'(data_i);
        hit_q <= 1'b1;
      end
    end
  end

  assign peak_val_o = peak_val_q;
  assign peak_idx_o = peak_idx_q;
  assign sum_o      = sum_q;
  assign hit_o      = hit_q;

endmodule

// File: rtl/hit_locator.sv
// Scans both axis sample arrays after each completed frame and emits one
// peak/sum event record per frame.
module hit_locator
  import autorad_pkg::*;
#(
  parameter logic [DATA_W-1:0] THRESHOLD = 16'd256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              finished,
  output logic [IDX_W-1:0]  read_index_yaxis,
  output logic [IDX_W-1:0]  read_index_xaxis,
  input  logic [DATA_W-1:0] out_data_yaxis,
  input  logic [DATA_W-1:0] out_data_xaxis,
  hit_locator_if.master     ev,
  output logic [7:0]        overrun_count,
  output state_t            dbg_state_o
);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             finished_q;
  logic [7:0]       overrun_q;
  logic             start;
  logic             clear;
  logic             enable;

  // finished_q resets high so a level already present at reset release is
  // not mistaken for a new frame.
  assign start  = finished & ~finished_q;
  assign clear  = (state_q == IDLE) & start;
  assign enable = (state_q == SCAN);

  // Frame FSM, edge detect, scan index and saturating overrun counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      finished_q <= 1'b1;
      overrun_q  <= '0;
    end else begin
      finished_q <= finished;
      if (start && (state_q != IDLE) && (overrun_q != 8'hFF))
        overrun_q <= overrun_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          idx_q <= idx_q + 7'd1;
          if (idx_q == 7'd127) begin
            state_q <= OUTPUT;
            valid_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (ev.event_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign read_index_yaxis = enable ? idx_q : '0;
  assign read_index_xaxis = enable ? idx_q : '0;

  axis_peak_accum #(.THRESHOLD(THRESHOLD)) u_axis_y (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (clear),
    .enable_i   (enable),
    .idx_i      (idx_q),
    .data_i     (out_data_yaxis),
    .peak_val_o (ev.peak_val_y),
    .peak_idx_o (ev.peak_idx_y),
    .sum_o      (ev.sum_y),
    .hit_o      (ev.hit_y)
  );

  axis_peak_accum #(.THRESHOLD(THRESHOLD)) u_axis_x (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (clear),
    .enable_i   (enable),
    .idx_i      (idx_q),
    .data_i     (out_data_xaxis),
    .peak_val_o (ev.peak_val_x),
    .peak_idx_o (ev.peak_idx_x),
    .sum_o      (ev.sum_x),
    .hit_o      (ev.hit_x)
  );

  assign ev.event_valid = valid_q;
  assign overrun_count  = overrun_q;
  assign dbg_state_o    = state_q;

endmodule
